// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel divider, h/v counters, visible enable, delayed syncs.
// Optional 16-bit frame counter output is built when VGA_FRAME_COUNTER_EN is defined.
module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       clk_in,
  input  logic       rst_n,
  output logic [9:0] current_row,
  output logic [9:0] current_line,
  output logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       pixel_tick,
`ifdef VGA_FRAME_COUNTER_EN
  output logic [15:0] frame_count,
`endif
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0]    div_q, div_d;
  logic [9:0]          h_q, h_d;
  logic [9:0]          v_q, v_d;
  logic                tick;
  logic                frame_wrap;
  logic                en_q, pt_q, fs_q;
  logic                hs_raw_d, vs_raw_d;
  logic [SYNC_DELAY:0] hs_pipe_q, vs_pipe_q;
  logic [SYNC_DELAY+1:0] hs_shift, vs_shift;

  assign tick  = (div_q >= DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  // Out-of-range counts (unreachable) fall back to 0 on the next tick.
  always_comb begin
    h_d        = h_q;
    v_d        = v_q;
    frame_wrap = 1'b0;
    if (tick) begin
      if (h_q >= H_LAST) begin
        h_d = '0;
        if (v_q >= V_LAST) begin
          v_d        = '0;
          frame_wrap = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
        if (v_q > V_LAST) v_d = '0;
      end
    end
  end

  // Syncs decode the next counter values so stage 0 lines up with the counters.
  assign hs_raw_d = !((h_d >= HS_START) && (h_d < HS_END));
  assign vs_raw_d = !((v_d >= VS_START) && (v_d < VS_END));
  assign hs_shift = {hs_pipe_q, hs_raw_d};
  assign vs_shift = {vs_pipe_q, vs_raw_d};

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      div_q     <= '0;
      h_q       <= '0;
      v_q       <= '0;
      en_q      <= 1'b0;
      pt_q      <= 1'b0;
      fs_q      <= 1'b0;
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
    end else begin
      div_q     <= div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      en_q      <= (h_d < H_VIS) && (v_d < V_VIS);
      pt_q      <= tick;
      fs_q      <= frame_wrap;
      hs_pipe_q <= hs_shift[SYNC_DELAY:0];
      vs_pipe_q <= vs_shift[SYNC_DELAY:0];
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] fc_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n)          fc_q <= '0;
    else if (frame_wrap) fc_q <= fc_q + 16'd1;
  end

  assign frame_count = fc_q;
`endif

  assign current_row  = h_q;
  assign current_line = v_q;
  assign enable       = en_q;
  assign pixel_tick   = pt_q;
  assign frame_start  = fs_q;
  assign hsync        = hs_pipe_q[SYNC_DELAY];
  assign vsync        = vs_pipe_q[SYNC_DELAY];

endmodule
